rs_issue_queue: RTL and testbench

- Parametrised reservation station with NUM_ALU ALU issue ports and one load/store issue port.
- Sits between the ROB/decode dispatch stage and the ALUs/LSB. It accepts pre-decoded entries with operands already resolved as either a value or a ROB tag.
- Wakes entries from the CDB and issues the oldest ready entries first through valid/ready handshakes.
- Adds dispatch backpressure, age-ordered select, per-port stall and an occupancy count.

---
 rtl/rs_issue_queue_if.sv | 61 ++++++
 rtl/rs_issue_queue.sv | 190 +++++++++++++++++++
 tb/tb_rs_issue_queue.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_queue_if.sv
// Dispatch, CDB and issue-port bundle for the reservation station.
// The dispatcher/consumer side uses master; the queue uses slave.
interface rs_issue_queue_if #(
  parameter int DEPTH   = 16,
  parameter int NUM_ALU = 2,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                      disp_valid;
  logic                      disp_ready;
  logic [OP_W-1:0]           disp_op;
  logic                      disp_is_ls;
  logic [TAG_W-1:0]          disp_tag;
  logic                      disp_r1;
  logic                      disp_r2;
  logic [TAG_W-1:0]          disp_t1;
  logic [TAG_W-1:0]          disp_t2;
  logic [XLEN-1:0]           disp_v1;
  logic [XLEN-1:0]           disp_v2;
  logic [XLEN-1:0]           disp_imm;

  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [XLEN-1:0]           cdb_value;

  logic [NUM_ALU-1:0]        alu_valid;
  logic [NUM_ALU-1:0]        alu_ready;
  logic [NUM_ALU*OP_W-1:0]   alu_op;
  logic [NUM_ALU*XLEN-1:0]   alu_rs1;
  logic [NUM_ALU*XLEN-1:0]   alu_rs2;
  logic [NUM_ALU*TAG_W-1:0]  alu_tag;

  logic                      ls_valid;
  logic                      ls_ready;
  logic [OP_W-1:0]           ls_op;
  logic [XLEN-1:0]           ls_rs1;
  logic [XLEN-1:0]           ls_rs2;
  logic [XLEN-1:0]           ls_imm;
  logic [TAG_W-1:0]          ls_tag;

  logic [CW-1:0]             count;

  modport master (
    output disp_valid, disp_op, disp_is_ls, disp_tag, disp_r1, disp_r2,
           disp_t1, disp_t2, disp_v1, disp_v2, disp_imm,
           cdb_valid, cdb_tag, cdb_value, alu_ready, ls_ready,
    input  disp_ready, alu_valid, alu_op, alu_rs1, alu_rs2, alu_tag,
           ls_valid, ls_op, ls_rs1, ls_rs2, ls_imm, ls_tag, count
  );

  modport slave (
    input  disp_valid, disp_op, disp_is_ls, disp_tag, disp_r1, disp_r2,
           disp_t1, disp_t2, disp_v1, disp_v2, disp_imm,
           cdb_valid, cdb_tag, cdb_value, alu_ready, ls_ready,
    output disp_ready, alu_valid, alu_op, alu_rs1, alu_rs2, alu_tag,
           ls_valid, ls_op, ls_rs1, ls_rs2, ls_imm, ls_tag, count
  );
endinterface

// File: rtl/rs_issue_queue.sv
// Reservation station: CDB wakeup, age-matrix oldest-first select,
// NUM_ALU ALU issue registers plus one load/store issue register.
module rs_issue_queue #(
  parameter int DEPTH   = 16,
  parameter int NUM_ALU = 2,
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  rs_issue_queue_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0]  ent_valid, ent_ls, ent_r1, ent_r2;
  logic [OP_W-1:0]   ent_op  [DEPTH];
  logic [TAG_W-1:0]  ent_tag [DEPTH];
  logic [TAG_W-1:0]  ent_t1  [DEPTH];
  logic [TAG_W-1:0]  ent_t2  [DEPTH];
  logic [XLEN-1:0]   ent_v1  [DEPTH];
  logic [XLEN-1:0]   ent_v2  [DEPTH];
  logic [XLEN-1:0]   ent_imm [DEPTH];
  // older[i][j] set means entry j was dispatched before entry i
  logic [DEPTH-1:0]  older   [DEPTH];
  logic [CW-1:0]     count_q;

  logic [NUM_ALU-1:0]        alu_valid_q;
  logic [NUM_ALU*OP_W-1:0]   alu_op_q;
  logic [NUM_ALU*XLEN-1:0]   alu_rs1_q, alu_rs2_q;
  logic [NUM_ALU*TAG_W-1:0]  alu_tag_q;
  logic                      ls_valid_q;
  logic [OP_W-1:0]           ls_op_q;
  logic [XLEN-1:0]           ls_rs1_q, ls_rs2_q, ls_imm_q;
  logic [TAG_W-1:0]          ls_tag_q;

  logic [DEPTH-1:0]   ent_rdy, taken, cand, ls_cand;
  logic [NUM_ALU-1:0] alu_hit, alu_load;
  logic [IW-1:0]      alu_idx [NUM_ALU];
  logic               ls_hit, ls_load;
  logic [IW-1:0]      ls_idx, free_idx;
  logic               free_found;
  logic [CW-1:0]      n_issue;
  logic               disp_fire;
  logic               byp1, byp2;

  assign ent_rdy   = ent_valid & ent_r1 & ent_r2;
  assign ls_load   = !ls_valid_q || bus.ls_ready;
  assign disp_fire = bus.disp_valid && bus.disp_ready;
  assign byp1 = bus.cdb_valid && !bus.disp_r1 && (bus.disp_t1 == bus.cdb_tag);
  assign byp2 = bus.cdb_valid && !bus.disp_r2 && (bus.disp_t2 == bus.cdb_tag);

  // An entry is oldest within a candidate set when no older candidate exists.
  always_comb begin
    taken   = '0;
    cand    = '0;
    alu_hit = '0;
    for (int unsigned k = 0; k < NUM_ALU; k++) begin
      alu_idx[k] = '0;
      cand = ent_rdy & ~ent_ls & ~taken;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (cand[i] && ((older[i] & cand) == '0)) begin
          alu_hit[k] = 1'b1;
          alu_idx[k] = IW'(i);
        end
      end
      if (alu_hit[k]) taken[alu_idx[k]] = 1'b1;
    end

    ls_cand = ent_rdy & ent_ls;
    ls_hit  = 1'b0;
    ls_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ls_cand[i] && ((older[i] & ls_cand) == '0)) begin
        ls_hit = 1'b1;
        ls_idx = IW'(i);
      end
    end
  end

  always_comb begin
    alu_load = ~alu_valid_q | bus.alu_ready;
    n_issue  = '0;
    for (int unsigned k = 0; k < NUM_ALU; k++)
      if (alu_load[k] && alu_hit[k]) n_issue = n_issue + CW'(1);
    if (ls_load && ls_hit) n_issue = n_issue + CW'(1);

    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!ent_valid[i] && !free_found) begin
        free_idx   = IW'(i);
        free_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (rdy && flush)) begin
      ent_valid   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) older[i] <= '0;
      count_q     <= '0;
      alu_valid_q <= '0;
      alu_op_q    <= '0;
      alu_rs1_q   <= '0;
      alu_rs2_q   <= '0;
      alu_tag_q   <= '0;
      ls_valid_q  <= 1'b0;
      ls_op_q     <= '0;
      ls_rs1_q    <= '0;
      ls_rs2_q    <= '0;
      ls_imm_q    <= '0;
      ls_tag_q    <= '0;
    end else if (rdy) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (ent_valid[i] && bus.cdb_valid) begin
          if (!ent_r1[i] && ent_t1[i] == bus.cdb_tag) begin
            ent_r1[i] <= 1'b1;
            ent_v1[i] <= bus.cdb_value;
          end
          if (!ent_r2[i] && ent_t2[i] == bus.cdb_tag) begin
            ent_r2[i] <= 1'b1;
            ent_v2[i] <= bus.cdb_value;
          end
        end
      end

      for (int unsigned k = 0; k < NUM_ALU; k++) begin
        if (alu_load[k]) begin
          alu_valid_q[k] <= alu_hit[k];
          if (alu_hit[k]) begin
            alu_op_q [k*OP_W  +: OP_W]  <= ent_op [alu_idx[k]];
            alu_rs1_q[k*XLEN  +: XLEN]  <= ent_v1 [alu_idx[k]];
            alu_rs2_q[k*XLEN  +: XLEN]  <= ent_v2 [alu_idx[k]];
            alu_tag_q[k*TAG_W +: TAG_W] <= ent_tag[alu_idx[k]];
            ent_valid[alu_idx[k]]       <= 1'b0;
          end
        end
      end

      if (ls_load) begin
        ls_valid_q <= ls_hit;
        if (ls_hit) begin
          ls_op_q           <= ent_op [ls_idx];
          ls_rs1_q          <= ent_v1 [ls_idx];
          ls_rs2_q          <= ent_v2 [ls_idx];
          ls_imm_q          <= ent_imm[ls_idx];
          ls_tag_q          <= ent_tag[ls_idx];
          ent_valid[ls_idx] <= 1'b0;
        end
      end

      // New entry is younger than every live one: row gets valid vector, column clears.
      if (disp_fire) begin
        ent_valid[free_idx] <= 1'b1;
        ent_ls  [free_idx]  <= bus.disp_is_ls;
        ent_op  [free_idx]  <= bus.disp_op;
        ent_tag [free_idx]  <= bus.disp_tag;
        ent_t1  [free_idx]  <= bus.disp_t1;
        ent_t2  [free_idx]  <= bus.disp_t2;
        ent_imm [free_idx]  <= bus.disp_imm;
        ent_r1  [free_idx]  <= bus.disp_r1 || byp1;
        ent_r2  [free_idx]  <= bus.disp_r2 || byp2;
        ent_v1  [free_idx]  <= byp1 ? bus.cdb_value : bus.disp_v1;
        ent_v2  [free_idx]  <= byp2 ? bus.cdb_value : bus.disp_v2;
        for (int unsigned i = 0; i < DEPTH; i++) older[i][free_idx] <= 1'b0;
        older[free_idx] <= ent_valid;
      end

      count_q <= count_q + CW'(disp_fire) - n_issue;
    end
  end

  assign bus.disp_ready = (count_q < CW'(DEPTH));
  assign bus.count      = count_q;
  assign bus.alu_valid  = alu_valid_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_rs1    = alu_rs1_q;
  assign bus.alu_rs2    = alu_rs2_q;
  assign bus.alu_tag    = alu_tag_q;
  assign bus.ls_valid   = ls_valid_q;
  assign bus.ls_op      = ls_op_q;
  assign bus.ls_rs1     = ls_rs1_q;
  assign bus.ls_rs2     = ls_rs2_q;
  assign bus.ls_imm     = ls_imm_q;
  assign bus.ls_tag     = ls_tag_q;
endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue with hand-computed expectations
// (DEPTH=16, NUM_ALU=2, XLEN=32, TAG_W=4, OP_W=6).
module tb_rs_issue_queue;
  logic clk = 1'b0;
  logic rst, rdy, flush;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  rs_issue_queue_if #(.DEPTH(16), .NUM_ALU(2), .XLEN(32), .TAG_W(4), .OP_W(6)) bus ();

  rs_issue_queue #(.DEPTH(16), .NUM_ALU(2), .XLEN(32), .TAG_W(4), .OP_W(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.cdb_valid  = 1'b0;
  endtask

  task automatic disp_set(input logic [5:0] op, input logic ls, input logic [3:0] tag,
                          input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                          input logic r2, input logic [3:0] t2, input logic [31:0] v2,
                          input logic [31:0] imm);
    bus.disp_valid = 1'b1;
    bus.disp_op    = op;
    bus.disp_is_ls = ls;
    bus.disp_tag   = tag;
    bus.disp_r1    = r1;
    bus.disp_t1    = t1;
    bus.disp_v1    = v1;
    bus.disp_r2    = r2;
    bus.disp_t2    = t2;
    bus.disp_v2    = v2;
    bus.disp_imm   = imm;
  endtask

  task automatic cdb_set(input logic [3:0] tag, input logic [31:0] val);
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = tag;
    bus.cdb_value = val;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    disp_set(6'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    idle();
    bus.cdb_tag = '0; bus.cdb_value = '0;
    bus.alu_ready = 2'b11; bus.ls_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
    check("rst_ls_valid", 64'(bus.ls_valid), 64'd0);
    check("rst_alu_op", 64'(bus.alu_op), 64'd0);
    check("rst_ls_imm", 64'(bus.ls_imm), 64'd0);

    // ADD with both operands ready
    disp_set(6'd28, 1'b0, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 32'd0);
    step(); idle();
    check("add_count1", 64'(bus.count), 64'd1);
    check("add_not_yet", 64'(bus.alu_valid), 64'd0);
    step();
    check("add_valid", 64'(bus.alu_valid), 64'b01);
    check("add_op", 64'(bus.alu_op[5:0]), 64'd28);
    check("add_rs1", 64'(bus.alu_rs1[31:0]), 64'd5);
    check("add_rs2", 64'(bus.alu_rs2[31:0]), 64'd7);
    check("add_tag", 64'(bus.alu_tag[3:0]), 64'd3);
    check("add_count0", 64'(bus.count), 64'd0);
    step();
    check("add_drop", 64'(bus.alu_valid), 64'd0);

    // ADDI waiting on tag 5, woken one cycle later
    disp_set(6'd19, 1'b0, 4'd2, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'h10, 32'h10);
    step(); idle();
    cdb_set(4'd5, 32'h100);
    step(); idle();
    check("wake_not_same", 64'(bus.alu_valid), 64'd0);
    step();
    check("wake_valid", 64'(bus.alu_valid), 64'b01);
    check("wake_rs1", 64'(bus.alu_rs1[31:0]), 64'h100);
    check("wake_rs2", 64'(bus.alu_rs2[31:0]), 64'h10);
    check("wake_op", 64'(bus.alu_op[5:0]), 64'd19);
    step();

    // Same, with the CDB broadcast in the dispatch cycle
    disp_set(6'd19, 1'b0, 4'd2, 1'b0, 4'd5, 32'd0, 1'b1, 4'd0, 32'h10, 32'h10);
    cdb_set(4'd5, 32'h200);
    step(); idle();
    step();
    check("byp_valid", 64'(bus.alu_valid), 64'b01);
    check("byp_rs1", 64'(bus.alu_rs1[31:0]), 64'h200);
    step();
    check("byp_drop", 64'(bus.alu_valid), 64'd0);

    // Fill all 16 slots waiting on tag 9
    for (int i = 0; i < 16; i++) begin
      disp_set(6'd28, 1'b0, 4'(i), 1'b0, 4'd9, 32'd0, 1'b1, 4'd0, 32'(i), 32'd0);
      step();
    end
    idle();
    check("full_count", 64'(bus.count), 64'd16);
    check("full_ready", 64'(bus.disp_ready), 64'd0);
    disp_set(6'd28, 1'b0, 4'd15, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 32'd0);
    step(); idle();
    check("full_ignored", 64'(bus.count), 64'd16);
    check("full_no_issue", 64'(bus.alu_valid), 64'd0);
    cdb_set(4'd9, 32'hAA);
    step(); idle();
    check("full_wake_count", 64'(bus.count), 64'd16);
    check("full_wake_nv", 64'(bus.alu_valid), 64'd0);
    for (int j = 0; j < 8; j++) begin
      step();
      check("drain_valid", 64'(bus.alu_valid), 64'b11);
      check("drain_tag0", 64'(bus.alu_tag[3:0]), 64'(2*j));
      check("drain_tag1", 64'(bus.alu_tag[7:4]), 64'(2*j+1));
      check("drain_rs2_0", 64'(bus.alu_rs2[31:0]), 64'(2*j));
      check("drain_rs1_1", 64'(bus.alu_rs1[63:32]), 64'hAA);
      check("drain_count", 64'(bus.count), 64'(14 - 2*j));
    end
    step();
    check("drain_empty", 64'(bus.alu_valid), 64'd0);

    // Port 0 stalled; port 1 keeps issuing
    bus.alu_ready = 2'b10;
    disp_set(6'd28, 1'b0, 4'd1, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h21, 32'd0);
    step();
    disp_set(6'd28, 1'b0, 4'd2, 1'b1, 4'd0, 32'h12, 1'b1, 4'd0, 32'h22, 32'd0);
    step();
    check("stall_v0", 64'(bus.alu_valid), 64'b01);
    check("stall_tag0", 64'(bus.alu_tag[3:0]), 64'd1);
    disp_set(6'd28, 1'b0, 4'd3, 1'b1, 4'd0, 32'h13, 1'b1, 4'd0, 32'h23, 32'd0);
    step(); idle();
    check("stall_hold1", 64'({bus.alu_op[5:0], bus.alu_tag[3:0], bus.alu_rs1[31:0]}),
          64'({6'd28, 4'd1, 32'h11}));
    check("stall_p1_idle", 64'(bus.alu_valid), 64'b01);
    step();
    check("stall_hold2_rs2", 64'(bus.alu_rs2[31:0]), 64'h21);
    check("stall_p1_valid", 64'(bus.alu_valid), 64'b11);
    check("stall_p1_tag", 64'(bus.alu_tag[7:4]), 64'd3);
    step();
    check("stall_hold3", 64'({bus.alu_tag[3:0], bus.alu_rs1[31:0]}), 64'({4'd1, 32'h11}));
    check("stall_p1_drop", 64'(bus.alu_valid), 64'b01);
    check("stall_count", 64'(bus.count), 64'd1);
    bus.alu_ready = 2'b11;
    step();
    check("stall_release", 64'(bus.alu_tag[3:0]), 64'd2);
    check("stall_rel_v", 64'(bus.alu_valid), 64'b01);
    step();
    check("stall_empty", 64'({bus.alu_valid, bus.count}), 64'd0);

    // Two loads: older waits on tag 7, younger ready
    disp_set(6'd13, 1'b1, 4'd4, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd0, 32'h40);
    step();
    disp_set(6'd13, 1'b1, 4'd5, 1'b1, 4'd0, 32'h1000, 1'b1, 4'd0, 32'd0, 32'h8);
    step(); idle();
    step();
    check("ls_young_v", 64'(bus.ls_valid), 64'd1);
    check("ls_young_tag", 64'(bus.ls_tag), 64'd5);
    check("ls_young_rs1", 64'(bus.ls_rs1), 64'h1000);
    check("ls_young_imm", 64'(bus.ls_imm), 64'h8);
    check("ls_no_alu", 64'(bus.alu_valid), 64'd0);
    cdb_set(4'd7, 32'h2000);
    step(); idle();
    check("ls_gap", 64'(bus.ls_valid), 64'd0);
    step();
    check("ls_old_v", 64'(bus.ls_valid), 64'd1);
    check("ls_old_tag", 64'(bus.ls_tag), 64'd4);
    check("ls_old_rs1", 64'(bus.ls_rs1), 64'h2000);
    check("ls_old_imm", 64'(bus.ls_imm), 64'h40);
    check("ls_old_op", 64'(bus.ls_op), 64'd13);
    step();
    check("ls_empty", 64'(bus.ls_valid), 64'd0);

    // Flush with entries pending and ls_valid held, preceded by an rdy-low cycle
    bus.ls_ready = 1'b0;
    disp_set(6'd13, 1'b1, 4'd6, 1'b1, 4'd0, 32'h3000, 1'b1, 4'd0, 32'h55, 32'h4);
    step();
    disp_set(6'd28, 1'b0, 4'd8, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0);
    step();
    disp_set(6'd28, 1'b0, 4'd9, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'd0, 32'd0);
    step(); idle();
    check("fl_pre_count", 64'(bus.count), 64'd2);
    check("fl_pre_ls", 64'({bus.ls_valid, bus.ls_tag}), 64'({1'b1, 4'd6}));
    rdy = 1'b0; flush = 1'b1; bus.ls_ready = 1'b1;
    disp_set(6'd28, 1'b0, 4'd10, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1, 32'd0);
    cdb_set(4'd12, 32'h77);
    step();
    check("frz_count", 64'(bus.count), 64'd2);
    check("frz_ls", 64'({bus.ls_valid, bus.ls_tag}), 64'({1'b1, 4'd6}));
    check("frz_ls_rs2", 64'(bus.ls_rs2), 64'h55);
    check("frz_alu", 64'(bus.alu_valid), 64'd0);
    rdy = 1'b1;
    step();
    flush = 1'b0; idle();
    check("fl_count", 64'(bus.count), 64'd0);
    check("fl_valids", 64'({bus.alu_valid, bus.ls_valid}), 64'd0);
    check("fl_disp_ready", 64'(bus.disp_ready), 64'd1);
    step();
    check("fl_nothing_left", 64'({bus.alu_valid, bus.ls_valid, bus.count}), 64'd0);
    disp_set(6'd28, 1'b0, 4'd7, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2, 32'd0);
    step(); idle();
    check("post_count", 64'(bus.count), 64'd1);
    step();
    check("post_valid", 64'(bus.alu_valid), 64'b01);
    check("post_tag", 64'(bus.alu_tag[3:0]), 64'd7);
    check("post_rs", 64'({bus.alu_rs1[31:0], bus.alu_rs2[31:0]}), {32'd1, 32'd2});
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
